// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared encodings and sizing helpers for the FIFO round-robin arbiter.
package fifo_arb_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] STALL = 2'd2;

  localparam int BURST_CNT_W = 4;
  localparam int NUM_IN_DEF  = 4;

  function automatic int grant_w(input int n);
    return $clog2(n);
  endfunction

  localparam int GRANT_W = grant_w(NUM_IN_DEF);

endpackage

// File: rtl/fifo_rr_arbiter_next_pick.sv
// Circular first-set search: lowest offset from start whose request bit is set.
module rr_next_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int GW     = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [GW-1:0]     start,
  output logic [GW-1:0]     idx,
  output logic              valid
);

  int pos;

  always_comb begin
    idx   = '0;
    pos   = 0;
    valid = |req;
    // walk offsets from far to near so the nearest hit overwrites
    for (int k = NUM_IN - 1; k >= 0; k--) begin
      pos = (int'(start) + k) % NUM_IN;
      if (req[pos[GW-1:0]]) idx = pos[GW-1:0];
    end
  end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin scheduler merging NUM_IN upstream FIFOs into one downstream FIFO.
// Define ARB_STRICT_PRIO_EN for fixed lowest-index-first priority instead.
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_SIZE = 6,
  parameter int NUM_IN    = 4,
  parameter int BURST     = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic [NUM_IN-1:0]           in_empty,
  input  logic [NUM_IN*DATA_SIZE-1:0] in_data,
  input  logic                        out_pause,
  input  logic                        out_full,
  output logic [NUM_IN-1:0]           in_pop,
  output logic                        out_push,
  output logic [DATA_SIZE-1:0]        out_data,
  output logic [$clog2(NUM_IN)-1:0]   grant_idx,
  output logic                        busy,
  output logic                        arb_error
);

  localparam int GW = grant_w(NUM_IN);

`ifdef ARB_STRICT_PRIO_EN
  localparam logic STRICT = 1'b1;
`else
  localparam logic STRICT = 1'b0;
`endif

  logic [1:0]             state;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [GW-1:0]          next_idx;
  logic [GW-1:0]          start_idx;
  logic [GW-1:0]          pick_idx;
  logic                   pick_valid;
  logic                   pop_ok;
  logic                   burst_done;
  logic                   valid_s1;
  logic [GW-1:0]          sel_s1;

  assign next_idx   = (grant_idx == GW'(NUM_IN - 1)) ? '0 : grant_idx + GW'(1);
  assign start_idx  = STRICT ? '0 : next_idx;
  assign burst_done = STRICT | (burst_cnt == BURST_CNT_W'(BURST - 1));

  rr_next_pick #(.NUM_IN(NUM_IN), .GW(GW)) u_pick (
    .req   (~in_empty),
    .start (start_idx),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  // gated by the live empty flag so an empty FIFO is never popped
  assign pop_ok = (state == GRANT) & ~in_empty[grant_idx] & ~out_pause & enable & ~reset;
  assign in_pop = pop_ok ? (NUM_IN'(1) << grant_idx) : '0;
  assign busy   = pop_ok | valid_s1 | out_push;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant_idx <= '0;
      burst_cnt <= '0;
      valid_s1  <= 1'b0;
      sel_s1    <= '0;
      out_push  <= 1'b0;
      out_data  <= '0;
      arb_error <= 1'b0;
    end else begin
      // stage 1: word appears on in_data; stage 2: registered push
      valid_s1 <= pop_ok;
      sel_s1   <= grant_idx;
      out_push <= valid_s1;
      if (valid_s1) out_data <= in_data[sel_s1*DATA_SIZE +: DATA_SIZE];
      if (out_push && out_full) arb_error <= 1'b1;

      case (state)
        IDLE: begin
          if (enable && pick_valid) begin
            state     <= GRANT;
            grant_idx <= pick_idx;
            burst_cnt <= '0;
          end
        end
        GRANT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (out_pause) begin
            state <= STALL;
          end else if (!pick_valid) begin
            state <= IDLE;
          end else if ((pop_ok && burst_done) || in_empty[grant_idx]) begin
            grant_idx <= pick_idx;
            burst_cnt <= '0;
          end else if (pop_ok && !burst_done) begin
            burst_cnt <= burst_cnt + BURST_CNT_W'(1);
          end
        end
        STALL: begin
          if (!out_pause) state <= GRANT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
